rv32_issue_ctrl: RTL and testbench
==================================

# rv32_issue_ctrl

Decode-stage issue controller for the RV32 pipeline. It sits beside the instruction decoder, consumes its register-use flags and destination info, and tracks in-flight register writes in a 3-entry scoreboard (EX, MEM, WB). From that scoreboard it decides each cycle whether the decoded instruction issues to EX, stalls, or is killed by a taken branch, and selects the operand bypass source for each source register. It also keeps a saturating count of hazard-stall cycles for performance monitoring.

## Interface
Parameters:
- BYPASS_EN, default 1: 1 = forward from EX/MEM/WB; 0 = no forwarding, stall on any match.
- CNT_W, default 16: width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- dec_valid  in  1  decode stage holds a valid instruction.
- dec_rs1, dec_rs2  in  5  source register indices.
- dec_use_rs  in  2  bit0 = rs1 read, bit1 = rs2 read (decoder use_rs).
- dec_rd  in  5  destination register index.
- dec_wb  in  1  instruction writes dec_rd (decoder register_wb, already 0 when rd = x0).
- dec_late  in  1  result produced by memory (load); not available from EX.
- ex_flush  in  1  taken branch/jump resolved in EX this cycle.
- stall_ext  in  1  pipeline freeze (memory wait); all stages hold.
- cnt_clr  in  1  synchronous clear of stall counter.
- dec_issue  out  1  decoded instruction moves to EX at this edge.
- dec_stall  out  1  hold fetch/decode registers.
- fwd_rs1, fwd_rs2  out  2  operand source: 0 regfile, 1 EX result, 2 MEM result, 3 WB result.
- stall_cnt  out  CNT_W  hazard-stall cycle count.

## Operation
- Scoreboard slots EX, MEM, WB, each {v, rd[4:0], late}. Slot "matches" operand i when v = 1, slot.rd = rs_i, rs_i != 0, dec_use_rs[i] = 1.
- Per operand, the youngest matching slot wins: EX over MEM over WB.
- Per-operand hazard (BYPASS_EN = 1): EX match with late = 1 -> hazard (load-use); EX match, late = 0 -> fwd 1; MEM match -> fwd 2 (late results valid at MEM output); WB match -> fwd 3; no match -> fwd 0.
- BYPASS_EN = 0: any match -> hazard; fwd always 0.
- hazard = dec_valid & (hazard_rs1 | hazard_rs2).
- dec_issue = dec_valid & ~hazard & ~stall_ext & ~ex_flush.
- dec_stall = stall_ext | (hazard & ~ex_flush). Flush beats hazard: the killed instruction is not stalled on.
- fwd_rs* driven whenever dec_valid; 0 when dec_valid = 0.
- Slot update, when stall_ext = 0: WB <= MEM; MEM <= EX; EX <= {dec_issue & dec_wb, dec_rd, dec_late}, so a stall or flush inserts a bubble (v = 0). When stall_ext = 1: all slots hold.
- ex_flush does not clear the EX slot (the branch itself, e.g. JAL, may write rd); it only prevents issue of the decode instruction.
- Counter: increments when hazard & ~ex_flush & ~stall_ext; saturates at all-ones; cnt_clr has priority over increment and sets 0.

## Timing
- Outputs dec_issue, dec_stall and fwd_* are combinational from inputs and registered slots; there is no added latency.
- Load-use: exactly 1 stall cycle with BYPASS_EN = 1. Without bypass, a dependent instruction stalls until the producer has left WB (up to 3 cycles).
- Reset (resetn low, asynchronous): all slot v = 0, rd = 0, late = 0; stall_cnt = 0. Outputs during reset: dec_issue = dec_valid & ~stall_ext & ~ex_flush, dec_stall = stall_ext, fwd = 0.
- Reset mid-stall drops all pending hazards; the first cycle after release has an empty scoreboard.
- stall_ext together with ex_flush: slots hold and dec_issue = 0. ex_flush is expected to remain asserted until the freeze ends.
- rd = x0 never enters a valid slot (dec_wb = 0); rs = x0 never matches.

## Test plan
- Back-to-back ALU dependency: addi x5 issued, then add x6, x5, x5 -> next cycle fwd_rs1 = fwd_rs2 = 1, dec_issue = 1, no stall.
- Load-use: lw x7 (dec_late = 1), then add uses x7 -> one cycle dec_stall = 1, dec_issue = 0, stall_cnt = 1; following cycle fwd = 2, issue.
- Distance 2 and 3: producer of x9 followed by 1 or 2 independent instructions -> consumer gets fwd 2 or 3; with both an EX and a WB match on x9, fwd = 1.
- x0 handling: writer with rd = 0, then reader of x0 with use_rs = 1 -> fwd 0, no stall; reader with use_rs = 0 of a pending reg -> no stall.
- Flush vs hazard: load-use hazard with ex_flush = 1 the same cycle -> dec_issue = 0, dec_stall = 0, stall_cnt unchanged, EX slot becomes bubble.
- stall_ext held 3 cycles with slots EX = x3, MEM = x4 -> slots unchanged throughout, dec_stall = 1; BYPASS_EN = 0 run: dependent on x3 stalls 3 cycles after release; counter saturates at 0xFFFF, cnt_clr returns it to 0.

Source files
------------

// File: rtl/rv32_issue_ctrl.sv
// Decode-stage issue controller for the RV32 pipeline.
// Tracks in-flight register writes in a 3-slot scoreboard (EX, MEM, WB).
// Each cycle it decides issue/stall/kill for the decoded instruction and
// picks the operand bypass source. It also keeps a saturating count of
// hazard-stall cycles for performance monitoring.
module rv32_issue_ctrl #(
    parameter bit BYPASS_EN = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             dec_valid,
    input  logic [4:0]       dec_rs1,
    input  logic [4:0]       dec_rs2,
    input  logic [1:0]       dec_use_rs,
    input  logic [4:0]       dec_rd,
    input  logic             dec_wb,
    input  logic             dec_late,
    input  logic             ex_flush,
    input  logic             stall_ext,
    input  logic             cnt_clr,
    output logic             dec_issue,
    output logic             dec_stall,
    output logic [1:0]       fwd_rs1,
    output logic [1:0]       fwd_rs2,
    output logic [CNT_W-1:0] stall_cnt
);

    // One in-flight register write; late = result only exists after memory.
    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       late;
    } slot_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_e;

    slot_t            ex_q, mem_q, wb_q;
    slot_t            ex_d, mem_d, wb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             haz_rs1, haz_rs2, hazard;
    logic [1:0]       raw_fwd1, raw_fwd2;

    // x0 is hard-wired to zero, so it never has a producer to wait on.
    function automatic logic slot_hit(slot_t s, logic [4:0] rs, logic rd_en);
        return s.v && (s.rd == rs) && (rs != 5'd0) && rd_en;
    endfunction

    // Youngest match wins; returns {hazard, forward source}.
    function automatic logic [2:0] resolve(slot_t ex, slot_t mem, slot_t wb,
                                           logic [4:0] rs, logic rd_en);
        logic haz;
        fwd_e fwd;
        haz = 1'b0;
        fwd = FWD_RF;
        if (slot_hit(ex, rs, rd_en)) begin
            // A load in EX has no result yet: that is the load-use bubble.
            if (!BYPASS_EN || ex.late) haz = 1'b1;
            else                       fwd = FWD_EX;
        end else if (slot_hit(mem, rs, rd_en)) begin
            if (!BYPASS_EN) haz = 1'b1;
            else            fwd = FWD_MEM;
        end else if (slot_hit(wb, rs, rd_en)) begin
            if (!BYPASS_EN) haz = 1'b1;
            else            fwd = FWD_WB;
        end
        return {haz, fwd};
    endfunction

    // Hazard detection, issue/stall decision and bypass selection.
    always_comb begin
        {haz_rs1, raw_fwd1} = resolve(ex_q, mem_q, wb_q, dec_rs1, dec_use_rs[0]);
        {haz_rs2, raw_fwd2} = resolve(ex_q, mem_q, wb_q, dec_rs2, dec_use_rs[1]);
        hazard    = dec_valid & (haz_rs1 | haz_rs2);
        dec_issue = dec_valid & ~hazard & ~stall_ext & ~ex_flush;
        // A flushed instruction is being killed, so it is not held.
        dec_stall = stall_ext | (hazard & ~ex_flush);
        fwd_rs1   = dec_valid ? raw_fwd1 : 2'd0;
        fwd_rs2   = dec_valid ? raw_fwd2 : 2'd0;
    end

    // Scoreboard advance and stall-counter next state.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        cnt_d = cnt_q;
        if (!stall_ext) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            // A stall or flush enters EX as a bubble; ex_flush leaves the
            // branch already in EX alone since it may write rd itself.
            ex_d  = '{v: dec_issue & dec_wb, rd: dec_rd, late: dec_late};
        end
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (hazard && !ex_flush && !stall_ext && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset empties the scoreboard and clears the counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            cnt_q <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_rv32_issue_ctrl.sv
// Directed bench for rv32_issue_ctrl. Two instances share the stimulus:
// dut uses the default bypassing configuration, dut_nb has bypass off and
// a 4-bit stall counter so that saturation is reachable quickly.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_rv32_issue_ctrl;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       dec_valid = 1'b0;
    logic [4:0] dec_rs1 = '0, dec_rs2 = '0, dec_rd = '0;
    logic [1:0] dec_use_rs = '0;
    logic       dec_wb = 1'b0, dec_late = 1'b0;
    logic       ex_flush = 1'b0, stall_ext = 1'b0, cnt_clr = 1'b0;

    logic        dec_issue, dec_stall;
    logic [1:0]  fwd_rs1, fwd_rs2;
    logic [15:0] stall_cnt;

    logic        nb_issue, nb_stall;
    logic [1:0]  nb_fwd_rs1, nb_fwd_rs2;
    logic [3:0]  nb_stall_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    rv32_issue_ctrl dut (
        .clk(clk), .resetn(resetn), .dec_valid(dec_valid),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_use_rs(dec_use_rs),
        .dec_rd(dec_rd), .dec_wb(dec_wb), .dec_late(dec_late),
        .ex_flush(ex_flush), .stall_ext(stall_ext), .cnt_clr(cnt_clr),
        .dec_issue(dec_issue), .dec_stall(dec_stall),
        .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .stall_cnt(stall_cnt)
    );

    rv32_issue_ctrl #(.BYPASS_EN(1'b0), .CNT_W(4)) dut_nb (
        .clk(clk), .resetn(resetn), .dec_valid(dec_valid),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_use_rs(dec_use_rs),
        .dec_rd(dec_rd), .dec_wb(dec_wb), .dec_late(dec_late),
        .ex_flush(ex_flush), .stall_ext(stall_ext), .cnt_clr(cnt_clr),
        .dec_issue(nb_issue), .dec_stall(nb_stall),
        .fwd_rs1(nb_fwd_rs1), .fwd_rs2(nb_fwd_rs2), .stall_cnt(nb_stall_cnt)
    );

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [1:0] u, input logic [4:0] rd,
                         input logic wb, input logic late);
        dec_valid  = v;
        dec_rs1    = rs1;
        dec_rs2    = rs2;
        dec_use_rs = u;
        dec_rd     = rd;
        dec_wb     = wb;
        dec_late   = late;
    endtask

    task automatic do_reset;
        resetn    = 1'b0;
        ex_flush  = 1'b0;
        stall_ext = 1'b0;
        cnt_clr   = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset;
        drive(1'b1, 5'd5, 5'd6, 2'b11, 5'd7, 1'b1, 1'b0);
        #2 resetn = 1'b0;
        #1;
        total_cnt++;
        if ({dec_issue, dec_stall, fwd_rs1, fwd_rs2} !== 6'b100000)
            $display("FAIL reset_outputs: got %b want %b", {dec_issue, dec_stall, fwd_rs1, fwd_rs2}, 6'b100000);
        else pass_cnt++;
        total_cnt++;
        if (stall_cnt !== 16'd0 || nb_stall_cnt !== 4'd0)
            $display("FAIL reset_counter: got %0d/%0d want 0/0", stall_cnt, nb_stall_cnt);
        else pass_cnt++;
        stall_ext = 1'b1;
        #1;
        total_cnt++;
        if ({dec_issue, dec_stall, fwd_rs1, fwd_rs2} !== 6'b010000)
            $display("FAIL reset_stall_ext: got %b want %b", {dec_issue, dec_stall, fwd_rs1, fwd_rs2}, 6'b010000);
        else pass_cnt++;
        stall_ext = 1'b0;
        ex_flush  = 1'b1;
        #1;
        total_cnt++;
        if ({dec_issue, dec_stall} !== 2'b00)
            $display("FAIL reset_flush: got %b want %b", {dec_issue, dec_stall}, 2'b00);
        else pass_cnt++;
        ex_flush = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_back_to_back;
        do_reset;
        drive(1'b1, 5'd1, 5'd0, 2'b01, 5'd5, 1'b1, 1'b0);   // addi x5, x1, imm
        #1;
        total_cnt++;
        if ({dec_issue, dec_stall, fwd_rs1, fwd_rs2} !== 6'b100000)
            $display("FAIL b2b_producer: got %b want %b", {dec_issue, dec_stall, fwd_rs1, fwd_rs2}, 6'b100000);
        else pass_cnt++;
        @(negedge clk);
        drive(1'b1, 5'd5, 5'd5, 2'b11, 5'd6, 1'b1, 1'b0);   // add x6, x5, x5
        #1;
        total_cnt++;
        if ({dec_issue, dec_stall, fwd_rs1, fwd_rs2} !== 6'b100101)
            $display("FAIL b2b_ex_fwd: got %b want %b", {dec_issue, dec_stall, fwd_rs1, fwd_rs2}, 6'b100101);
        else pass_cnt++;
        @(negedge clk);
        drive(1'b1, 5'd6, 5'd5, 2'b11, 5'd10, 1'b0, 1'b0);  // x6 in EX, x5 in MEM
        #1;
        total_cnt++;
        if ({dec_issue, dec_stall, fwd_rs1, fwd_rs2} !== 6'b100110)
            $display("FAIL b2b_ex_mem: got %b want %b", {dec_issue, dec_stall, fwd_rs1, fwd_rs2}, 6'b100110);
        else pass_cnt++;
        @(negedge clk);
        drive(1'b1, 5'd5, 5'd6, 2'b11, 5'd11, 1'b0, 1'b0);  // x5 in WB, x6 in MEM
        #1;
        total_cnt++;
        if ({dec_issue, dec_stall, fwd_rs1, fwd_rs2} !== 6'b101110)
            $display("FAIL b2b_wb_mem: got %b want %b", {dec_issue, dec_stall, fwd_rs1, fwd_rs2}, 6'b101110);
        else pass_cnt++;
        total_cnt++;
        if (stall_cnt !== 16'd0)
            $display("FAIL b2b_no_count: got %0d want 0", stall_cnt);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_load_use;
        do_reset;
        drive(1'b1, 5'd2, 5'd0, 2'b01, 5'd7, 1'b1, 1'b1);   // lw x7
        @(negedge clk);
        drive(1'b1, 5'd7, 5'd1, 2'b11, 5'd8, 1'b1, 1'b0);   // add x8, x7, x1
        #1;
        total_cnt++;
        if ({dec_issue, dec_stall} !== 2'b01)
            $display("FAIL load_use_stall: got %b want %b", {dec_issue, dec_stall}, 2'b01);
        else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++;
        if (stall_cnt !== 16'd1)
            $display("FAIL load_use_count: got %0d want 1", stall_cnt);
        else pass_cnt++;
        total_cnt++;
        if ({dec_issue, dec_stall, fwd_rs1, fwd_rs2} !== 6'b101000)
            $display("FAIL load_use_mem_fwd: got %b want %b", {dec_issue, dec_stall, fwd_rs1, fwd_rs2}, 6'b101000);
        else pass_cnt++;
        @(negedge clk);
        drive(1'b0, 5'd7, 5'd8, 2'b11, 5'd0, 1'b0, 1'b0);   // matches exist, but not valid
        #1;
        total_cnt++;
        if ({dec_issue, dec_stall, fwd_rs1, fwd_rs2} !== 6'b000000)
            $display("FAIL invalid_fwd_zero: got %b want %b", {dec_issue, dec_stall, fwd_rs1, fwd_rs2}, 6'b000000);
        else pass_cnt++;
        total_cnt++;
        if (stall_cnt !== 16'd1)
            $display("FAIL load_use_count_hold: got %0d want 1", stall_cnt);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_distance;
        do_reset;
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 1'b0);   // writes x9
        @(negedge clk);
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd10, 1'b1, 1'b0);  // independent
        @(negedge clk);
        drive(1'b1, 5'd9, 5'd0, 2'b01, 5'd9, 1'b1, 1'b0);   // reads and rewrites x9
        #1;
        total_cnt++;
        if ({dec_issue, dec_stall, fwd_rs1, fwd_rs2} !== 6'b101000)
            $display("FAIL dist2_mem: got %b want %b", {dec_issue, dec_stall, fwd_rs1, fwd_rs2}, 6'b101000);
        else pass_cnt++;
        @(negedge clk);
        drive(1'b1, 5'd9, 5'd9, 2'b11, 5'd14, 1'b0, 1'b0);  // x9 in EX and WB
        #1;
        total_cnt++;
        if ({dec_issue, dec_stall, fwd_rs1, fwd_rs2} !== 6'b100101)
            $display("FAIL youngest_wins: got %b want %b", {dec_issue, dec_stall, fwd_rs1, fwd_rs2}, 6'b100101);
        else pass_cnt++;
        @(negedge clk);
        do_reset;
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd10, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd11, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b1, 5'd0, 5'd9, 2'b10, 5'd12, 1'b1, 1'b0);  // x9 in WB
        #1;
        total_cnt++;
        if ({dec_issue, dec_stall, fwd_rs1, fwd_rs2} !== 6'b100011)
            $display("FAIL dist3_wb: got %b want %b", {dec_issue, dec_stall, fwd_rs1, fwd_rs2}, 6'b100011);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_x0;
        do_reset;
        drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd0, 1'b0, 1'b0);   // rd = x0, wb already 0
        @(negedge clk);
        drive(1'b1, 5'd0, 5'd0, 2'b11, 5'd13, 1'b1, 1'b0);  // reads x0 twice, writes x13
        #1;
        total_cnt++;
        if ({dec_issue, dec_stall, fwd_rs1, fwd_rs2} !== 6'b100000)
            $display("FAIL x0_read: got %b want %b", {dec_issue, dec_stall, fwd_rs1, fwd_rs2}, 6'b100000);
        else pass_cnt++;
        total_cnt++;
        if ({nb_issue, nb_stall} !== 2'b10)
            $display("FAIL x0_read_nobypass: got %b want %b", {nb_issue, nb_stall}, 2'b10);
        else pass_cnt++;
        @(negedge clk);
        drive(1'b1, 5'd13, 5'd13, 2'b00, 5'd14, 1'b0, 1'b0); // x13 pending, not read
        #1;
        total_cnt++;
        if ({dec_issue, dec_stall, fwd_rs1, fwd_rs2} !== 6'b100000)
            $display("FAIL unused_rs: got %b want %b", {dec_issue, dec_stall, fwd_rs1, fwd_rs2}, 6'b100000);
        else pass_cnt++;
        total_cnt++;
        if ({nb_issue, nb_stall} !== 2'b10)
            $display("FAIL unused_rs_nobypass: got %b want %b", {nb_issue, nb_stall}, 2'b10);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_flush;
        do_reset;
        drive(1'b1, 5'd2, 5'd0, 2'b01, 5'd7, 1'b1, 1'b1);   // lw x7
        @(negedge clk);
        drive(1'b1, 5'd7, 5'd1, 2'b11, 5'd7, 1'b1, 1'b0);   // add x7, x7, x1 under flush
        ex_flush = 1'b1;
        #1;
        total_cnt++;
        if ({dec_issue, dec_stall} !== 2'b00)
            $display("FAIL flush_beats_hazard: got %b want %b", {dec_issue, dec_stall}, 2'b00);
        else pass_cnt++;
        @(negedge clk);
        ex_flush = 1'b0;
        #1;
        total_cnt++;
        if (stall_cnt !== 16'd0)
            $display("FAIL flush_no_count: got %0d want 0", stall_cnt);
        else pass_cnt++;
        // EX must be a bubble; a wrongly issued add would give fwd_rs1 = 1.
        total_cnt++;
        if ({dec_issue, dec_stall, fwd_rs1, fwd_rs2} !== 6'b101000)
            $display("FAIL flush_bubble: got %b want %b", {dec_issue, dec_stall, fwd_rs1, fwd_rs2}, 6'b101000);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_stall_ext;
        do_reset;
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b1, 5'd3, 5'd4, 2'b11, 5'd13, 1'b1, 1'b0);  // EX = x3, MEM = x4
        stall_ext = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total_cnt++;
            if ({dec_issue, dec_stall, fwd_rs1, fwd_rs2} !== 6'b010110)
                $display("FAIL freeze_hold_%0d: got %b want %b", i, {dec_issue, dec_stall, fwd_rs1, fwd_rs2}, 6'b010110);
            else pass_cnt++;
            @(negedge clk);
        end
        total_cnt++;
        if (stall_cnt !== 16'd0 || nb_stall_cnt !== 4'd0)
            $display("FAIL freeze_no_count: got %0d/%0d want 0/0", stall_cnt, nb_stall_cnt);
        else pass_cnt++;
        stall_ext = 1'b0;
        #1;
        total_cnt++;
        if ({dec_issue, dec_stall, fwd_rs1, fwd_rs2} !== 6'b100110)
            $display("FAIL freeze_release: got %b want %b", {dec_issue, dec_stall, fwd_rs1, fwd_rs2}, 6'b100110);
        else pass_cnt++;
        total_cnt++;
        if ({nb_fwd_rs1, nb_fwd_rs2} !== 4'b0000)
            $display("FAIL nobypass_fwd_zero: got %b want %b", {nb_fwd_rs1, nb_fwd_rs2}, 4'b0000);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) #1;
            total_cnt++;
            if ({nb_issue, nb_stall} !== ((i < 3) ? 2'b01 : 2'b10))
                $display("FAIL nobypass_drain_%0d: got %b want %b", i, {nb_issue, nb_stall}, (i < 3) ? 2'b01 : 2'b10);
            else pass_cnt++;
            @(negedge clk);
        end
        #1;
        total_cnt++;
        if (nb_stall_cnt !== 4'd3)
            $display("FAIL nobypass_count: got %0d want 3", nb_stall_cnt);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_saturate;
        do_reset;
        // Self-dependent chain: without bypass each one stalls 3 cycles.
        drive(1'b1, 5'd1, 5'd0, 2'b01, 5'd1, 1'b1, 1'b0);
        repeat (8) @(negedge clk);
        #1;
        total_cnt++;
        if (nb_stall_cnt !== 4'd6)
            $display("FAIL sat_partial: got %0d want 6", nb_stall_cnt);
        else pass_cnt++;
        repeat (16) @(negedge clk);
        #1;
        total_cnt++;
        if (nb_stall_cnt !== 4'hF)
            $display("FAIL sat_hold: got %0d want 15", nb_stall_cnt);
        else pass_cnt++;
        total_cnt++;
        if (stall_cnt !== 16'd0)
            $display("FAIL sat_bypass_zero: got %0d want 0", stall_cnt);
        else pass_cnt++;
        cnt_clr = 1'b1;
        repeat (2) @(negedge clk);   // second edge also has a hazard
        cnt_clr = 1'b0;
        #1;
        total_cnt++;
        if (nb_stall_cnt !== 4'd0)
            $display("FAIL clr_priority: got %0d want 0", nb_stall_cnt);
        else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++;
        if (nb_stall_cnt !== 4'd1)
            $display("FAIL count_resume: got %0d want 1", nb_stall_cnt);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_stall;
        do_reset;
        drive(1'b1, 5'd2, 5'd0, 2'b01, 5'd7, 1'b1, 1'b1);   // lw x7
        @(negedge clk);
        drive(1'b1, 5'd7, 5'd0, 2'b01, 5'd8, 1'b1, 1'b0);
        #1;
        total_cnt++;
        if ({dec_issue, dec_stall} !== 2'b01)
            $display("FAIL mid_stall_pre: got %b want %b", {dec_issue, dec_stall}, 2'b01);
        else pass_cnt++;
        #2 resetn = 1'b0;
        #1;
        total_cnt++;
        if ({dec_issue, dec_stall, fwd_rs1, fwd_rs2} !== 6'b100000)
            $display("FAIL mid_stall_reset: got %b want %b", {dec_issue, dec_stall, fwd_rs1, fwd_rs2}, 6'b100000);
        else pass_cnt++;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        total_cnt++;
        if ({dec_issue, dec_stall, fwd_rs1, fwd_rs2, stall_cnt} !== {6'b100000, 16'd0})
            $display("FAIL mid_stall_release: got %b/%0d want 100000/0", {dec_issue, dec_stall, fwd_rs1, fwd_rs2}, stall_cnt);
        else pass_cnt++;
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_back_to_back;
        test_load_use;
        test_distance;
        test_x0;
        test_flush;
        test_stall_ext;
        test_saturate;
        test_reset_mid_stall;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
